// File: rtl/hazard_forward_tracker.sv
// Shadow-pipeline hazard and forwarding unit: tracks in-flight destination records
// for EXE..WB, produces the ID stall, the EXE operand forward selects and a stall counter.
`timescale 1ns/1ps
module hazard_forward_tracker #(
  parameter int DEPTH      = 3,
  parameter int NUM_SRC    = 2,
  parameter int AW         = 4,
  parameter int LOAD_READY = 2,
  parameter int SEL_W      = $clog2(DEPTH),
  parameter int CNT_W      = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     freeze,
  input  logic                     flush,
  input  logic                     forwarding_en,
  input  logic                     id_valid,
  input  logic [NUM_SRC*AW-1:0]    id_src,
  input  logic [NUM_SRC-1:0]       id_src_used,
  input  logic [AW-1:0]            id_dest,
  input  logic                     id_wb_en,
  input  logic                     id_mem_r_en,
  output logic                     hazard,
  output logic [NUM_SRC*SEL_W-1:0] fwd_sel,
  output logic [CNT_W-1:0]         stall_count
);

  // Per-stage record, index 0 = EXE .. DEPTH-1 = WB
  logic [DEPTH-1:0]        r_vld;
  logic [DEPTH-1:0]        r_wb;
  logic [DEPTH-1:0]        r_ld;
  logic [AW-1:0]           r_dest [DEPTH];
  logic [NUM_SRC-1:0]      r_exe_used;
  logic [NUM_SRC*AW-1:0]   r_exe_src;
  logic [CNT_W-1:0]        r_cnt;

  logic                    w_raw_hazard;
  logic                    w_hazard;
  logic                    w_issue;
  logic [NUM_SRC*SEL_W-1:0] w_fwd_sel;

  function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // ID stage: RAW check of each used source against every in-flight producer
  always_comb begin
    w_raw_hazard = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (id_src_used[i] && r_vld[k] && r_wb[k] &&
            (r_dest[k] == id_src[i*AW +: AW])) begin
          // The WB stage writes through the register file, so it never stalls.
          if (!forwarding_en && (k < DEPTH - 1))
            w_raw_hazard = 1'b1;
          if (forwarding_en && r_ld[k] && (k < LOAD_READY - 1))
            w_raw_hazard = 1'b1;
        end
      end
    end
  end

  assign w_hazard = id_valid & w_raw_hazard;
  assign w_issue  = id_valid & ~w_hazard & ~flush;

  // EXE stage: scan oldest to youngest so the youngest valid producer wins
  always_comb begin
    w_fwd_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        if (forwarding_en && r_exe_used[i] && r_vld[k] && r_wb[k] &&
            (r_dest[k] == r_exe_src[i*AW +: AW]) &&
            !(r_ld[k] && (k < LOAD_READY)))
          w_fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k);
      end
    end
  end

  // Record control: valid/wb/load/src_used shift, counter tracks stall edges
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld      <= '0;
      r_wb       <= '0;
      r_ld       <= '0;
      r_exe_used <= '0;
      r_cnt      <= '0;
    end else if (!freeze) begin
      r_vld      <= {r_vld[DEPTH-2:0], w_issue};
      r_wb       <= {r_wb[DEPTH-2:0],  w_issue & id_wb_en};
      r_ld       <= {r_ld[DEPTH-2:0],  w_issue & id_mem_r_en};
      r_exe_used <= w_issue ? id_src_used : '0;
      if (w_hazard)
        r_cnt <= f_sat_inc(r_cnt);
    end
  end

  // Record payload: qualified by the valid/used bits above, so no reset needed
  always_ff @(posedge clk) begin
    if (!freeze) begin
      r_dest[0] <= id_dest;
      for (int k = 1; k < DEPTH; k++)
        r_dest[k] <= r_dest[k-1];
      r_exe_src <= id_src;
    end
  end

  assign hazard      = w_hazard;
  assign fwd_sel     = w_fwd_sel;
  assign stall_count = r_cnt;

endmodule

// File: tb/tb_hazard_forward_tracker.sv
// Bench for hazard_forward_tracker: three configurations driven in lockstep,
// compared every cycle against an age-ordered instruction history model.
`timescale 1ns/1ps
module tb_hazard_forward_tracker;

  logic       clk = 1'b0;
  logic       rst;
  logic       freeze;
  logic       flush;
  logic       fe;
  logic       id_valid;
  logic [7:0] id_src;
  logic [1:0] id_used;
  logic [3:0] id_dest;
  logic       id_wb;
  logic       id_ld;

  logic        haz_a, haz_b, haz_c;
  logic [3:0]  fs_a, fs_b, fs_c;
  logic [15:0] cnt_a, cnt_b;
  logic [1:0]  cnt_c;

  always #5 clk = ~clk;

  hazard_forward_tracker #(.DEPTH(3), .NUM_SRC(2), .AW(4), .LOAD_READY(2), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .forwarding_en(fe),
    .id_valid(id_valid), .id_src(id_src), .id_src_used(id_used), .id_dest(id_dest),
    .id_wb_en(id_wb), .id_mem_r_en(id_ld), .hazard(haz_a), .fwd_sel(fs_a), .stall_count(cnt_a));

  hazard_forward_tracker #(.DEPTH(4), .NUM_SRC(2), .AW(4), .LOAD_READY(3), .CNT_W(16)) u_b (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .forwarding_en(fe),
    .id_valid(id_valid), .id_src(id_src), .id_src_used(id_used), .id_dest(id_dest),
    .id_wb_en(id_wb), .id_mem_r_en(id_ld), .hazard(haz_b), .fwd_sel(fs_b), .stall_count(cnt_b));

  hazard_forward_tracker #(.DEPTH(3), .NUM_SRC(2), .AW(4), .LOAD_READY(2), .CNT_W(2)) u_c (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .forwarding_en(fe),
    .id_valid(id_valid), .id_src(id_src), .id_src_used(id_used), .id_dest(id_dest),
    .id_wb_en(id_wb), .id_mem_r_en(id_ld), .hazard(haz_c), .fwd_sel(fs_c), .stall_count(cnt_c));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // Reference model: hist[c][a] is the slot issued a advances ago (0 = now in EXE)
  typedef struct packed {
    logic       v;
    logic [3:0] dest;
    logic       wb;
    logic       ld;
    logic [3:0] s0;
    logic [3:0] s1;
    logic [1:0] used;
  } slot_t;

  localparam int DEP  [3] = '{3, 4, 3};
  localparam int LR   [3] = '{2, 3, 2};
  localparam int CMAX [3] = '{65535, 65535, 3};

  slot_t hist [3][8];
  int    mcnt [3];

  function automatic logic [3:0] id_s(input int i);
    return id_src[i*4 +: 4];
  endfunction

  function automatic bit produces(input slot_t s, input logic [3:0] a);
    return s.v && s.wb && (s.dest == a);
  endfunction

  function automatic bit m_haz(input int c);
    if (!id_valid) return 1'b0;
    for (int i = 0; i < 2; i++)
      for (int a = 0; a < DEP[c]; a++)
        if (id_used[i] && produces(hist[c][a], id_s(i))) begin
          if (!fe && a <= DEP[c] - 2) return 1'b1;
          if (fe && hist[c][a].ld && a + 1 < LR[c]) return 1'b1;
        end
    return 1'b0;
  endfunction

  function automatic int m_fwd(input int c, input int i);
    logic [3:0] a;
    if (!fe || !hist[c][0].used[i]) return 0;
    a = (i == 0) ? hist[c][0].s0 : hist[c][0].s1;
    for (int k = 1; k < DEP[c]; k++)
      if (produces(hist[c][k], a) && !(hist[c][k].ld && k < LR[c]))
        return k;
    return 0;
  endfunction

  task automatic m_reset();
    for (int c = 0; c < 3; c++) begin
      mcnt[c] = 0;
      for (int k = 0; k < 8; k++) hist[c][k] = '0;
    end
  endtask

  task automatic m_adv();
    slot_t n;
    bit    h;
    for (int c = 0; c < 3; c++) begin
      if (!freeze) begin
        h = m_haz(c);
        n = '0;
        if (id_valid && !h && !flush) begin
          n.v = 1'b1; n.dest = id_dest; n.wb = id_wb; n.ld = id_ld;
          n.s0 = id_s(0); n.s1 = id_s(1); n.used = id_used;
        end
        if (h && mcnt[c] < CMAX[c]) mcnt[c]++;
        for (int k = 7; k >= 1; k--) hist[c][k] = hist[c][k-1];
        hist[c][0] = n;
      end
    end
  endtask

  function automatic int d_haz(input int c);
    case (c)
      0: return int'(haz_a);
      1: return int'(haz_b);
      default: return int'(haz_c);
    endcase
  endfunction

  function automatic int d_fs(input int c, input int i);
    case (c)
      0: return int'(fs_a[i*2 +: 2]);
      1: return int'(fs_b[i*2 +: 2]);
      default: return int'(fs_c[i*2 +: 2]);
    endcase
  endfunction

  function automatic int d_cnt(input int c);
    case (c)
      0: return int'(cnt_a);
      1: return int'(cnt_b);
      default: return int'(cnt_c);
    endcase
  endfunction

  task automatic check_all();
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("haz_c%0d", c), d_haz(c), int'(m_haz(c)));
      chk($sformatf("fwd0_c%0d", c), d_fs(c, 0), m_fwd(c, 0));
      chk($sformatf("fwd1_c%0d", c), d_fs(c, 1), m_fwd(c, 1));
      chk($sformatf("cnt_c%0d", c), d_cnt(c), mcnt[c]);
    end
  endtask

  task automatic half();
    @(negedge clk);
    check_all();
  endtask

  task automatic adv();
    m_adv();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input bit [3:0] d, input bit wb, input bit ld,
                       input bit [3:0] s0, input bit [3:0] s1, input bit [1:0] u);
    id_valid = v; id_dest = d; id_wb = wb; id_ld = ld; id_src = {s1, s0}; id_used = u;
  endtask

  task automatic mid_reset();
    #1 rst = 1'b1;
    #1;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("rst_haz_c%0d", c), d_haz(c), 0);
      chk($sformatf("rst_fwd_c%0d", c), d_fs(c, 0) + d_fs(c, 1), 0);
      chk($sformatf("rst_cnt_c%0d", c), d_cnt(c), 0);
    end
    m_reset();
    #1 rst = 1'b0;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    freeze = 1'b0;
    flush  = 1'b0;
    @(negedge clk);
    mid_reset();
    adv();
  endtask

  function automatic logic [3:0] rreg();
    int r;
    r = $urandom_range(0, 4);
    return (r == 4) ? 4'hF : 4'(r);
  endfunction

  initial begin
    rst = 1'b1; freeze = 1'b0; flush = 1'b0; fe = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    m_reset();
    #12 rst = 1'b0;
    @(posedge clk); #1;

    // Reset with R1 producers in flight
    fe = 1'b0;
    drive(1, 1, 1, 0, 2, 3, 3); half(); adv();
    drive(1, 1, 1, 1, 2, 3, 3); half(); adv();
    do_reset();
    drive(1, 2, 1, 0, 1, 1, 3); half();
    chk("t1_haz_after_rst", int'(haz_a), 0);
    adv();

    // No forwarding: back-to-back RAW stalls two cycles
    do_reset(); fe = 1'b0;
    drive(1, 1, 1, 0, 8, 9, 3); half(); adv();
    drive(1, 2, 1, 0, 1, 3, 3); half();
    chk("t2_haz_c1", int'(haz_a), 1); adv();
    half(); chk("t2_haz_c2", int'(haz_a), 1); adv();
    half(); chk("t2_haz_c3", int'(haz_a), 0); adv();
    drive(0, 0, 0, 0, 0, 0, 0); half();
    chk("t2_cnt", int'(cnt_a), 2);
    chk("t2_fwd", int'(fs_a), 0);
    adv();

    // Forwarding: ALU result from MEM, then from WB
    do_reset(); fe = 1'b1;
    drive(1, 1, 1, 0, 8, 9, 3); half(); adv();
    drive(1, 2, 1, 0, 1, 3, 3); half();
    chk("t3_haz", int'(haz_a), 0); adv();
    drive(0, 0, 0, 0, 0, 0, 0); half();
    chk("t3_fwd0_mem", int'(fs_a[1:0]), 1);
    chk("t3_fwd1", int'(fs_a[3:2]), 0);
    adv();
    do_reset(); fe = 1'b1;
    drive(1, 1, 1, 0, 8, 9, 3); half(); adv();
    drive(1, 7, 1, 0, 8, 9, 3); half(); adv();
    drive(1, 2, 1, 0, 1, 3, 3); half(); adv();
    drive(0, 0, 0, 0, 0, 0, 0); half();
    chk("t3_fwd0_wb", int'(fs_a[1:0]), 2);
    adv();

    // Load-use: one stall at depth 3, two at depth 4 / ready 3
    do_reset(); fe = 1'b1;
    drive(1, 4, 1, 1, 5, 5, 1); half(); adv();
    drive(1, 5, 1, 0, 4, 4, 3); half();
    chk("t4_haz1", int'(haz_a), 1); adv();
    half(); chk("t4_haz2", int'(haz_a), 0); adv();
    half();
    chk("t4_fwd0", int'(fs_a[1:0]), 2);
    chk("t4_fwd1", int'(fs_a[3:2]), 2);
    chk("t4_cnt", int'(cnt_a), 1);
    adv();
    drive(0, 0, 0, 0, 0, 0, 0); half();
    chk("t4_d4_fwd0", int'(fs_b[1:0]), 3);
    chk("t4_d4_fwd1", int'(fs_b[3:2]), 3);
    chk("t4_d4_cnt", int'(cnt_b), 2);
    adv();

    // Youngest producer wins; unused source never forwards
    do_reset(); fe = 1'b1;
    drive(1, 1, 1, 0, 8, 9, 3); half(); adv();
    drive(1, 1, 1, 0, 8, 9, 3); half(); adv();
    drive(1, 2, 1, 0, 1, 1, 2'b01); half(); adv();
    drive(0, 0, 0, 0, 0, 0, 0); half();
    chk("t5_fwd0_young", int'(fs_a[1:0]), 1);
    chk("t5_fwd1_unused", int'(fs_a[3:2]), 0);
    adv();

    // Freeze holds a pending hazard without counting
    do_reset(); fe = 1'b0;
    drive(1, 1, 1, 0, 8, 9, 3); half(); adv();
    drive(1, 2, 1, 0, 1, 3, 3); freeze = 1'b1;
    for (int n = 0; n < 5; n++) begin
      half();
      chk("t6_frz_haz", int'(haz_a), 1);
      chk("t6_frz_cnt", int'(cnt_a), 0);
      adv();
    end
    freeze = 1'b0;
    for (int n = 0; n < 3; n++) begin half(); adv(); end
    drive(0, 0, 0, 0, 0, 0, 0); half();
    chk("t6_cnt_after", int'(cnt_a), 2);
    adv();

    // Flush raised during freeze squashes on the first unfrozen edge
    do_reset(); fe = 1'b0;
    freeze = 1'b1; flush = 1'b1;
    drive(1, 6, 1, 0, 8, 9, 3);
    half(); adv(); half(); adv();
    freeze = 1'b0; half(); adv();
    flush = 1'b0;
    drive(1, 7, 1, 0, 6, 6, 3); half();
    chk("t6_flush_haz", int'(haz_a), 0);
    adv();

    // Counter saturation at CNT_W=2
    do_reset(); fe = 1'b0;
    for (int p = 0; p < 3; p++) begin
      drive(1, 1, 1, 0, 8, 9, 3); half(); adv();
      drive(1, 2, 1, 0, 1, 3, 3);
      for (int n = 0; n < 3; n++) begin half(); adv(); end
    end
    drive(0, 0, 0, 0, 0, 0, 0); half();
    chk("t6_sat_cnt2", int'(cnt_c), 3);
    chk("t6_cnt16", int'(cnt_a), 6);
    adv();

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 49) == 0) fe = ~fe;
      id_valid = ($urandom_range(0, 9) < 8);
      id_dest  = rreg();
      id_src   = {rreg(), rreg()};
      id_used  = 2'($urandom_range(0, 3));
      id_wb    = ($urandom_range(0, 19) < 17);
      id_ld    = ($urandom_range(0, 9) < 3);
      freeze   = ($urandom_range(0, 9) < 2);
      flush    = ($urandom_range(0, 9) < 1);
      half();
      if ($urandom_range(0, 199) == 0) mid_reset();
      adv();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_forward_tracker.md
Name: hazard_forward_tracker

Overview:
Parametrised successor to the separate combinational hazard-detection and forwarding units. It holds its own shadow pipeline of in-flight destination records for the EXE..WB stages, so it needs no per-stage dest/wb_en taps. From that record it produces the ID-stage stall, the per-source forwarding selects for the instruction in EXE, and a stall-cycle performance counter. Pipeline depth, source count, register-address width and load-data readiness stage are all generic, so deeper memory pipelines and 3-source instructions reuse the same block.

Parameters:
DEPTH, 3, tracked stages after ID (index 0=EXE, 1=MEM, …, DEPTH-1=WB); legal range 2..8
NUM_SRC, 2, source operands per instruction; legal range 1..4
AW, 4, register address width
LOAD_READY, 2, first stage index whose load data is forwardable; legal range 1..DEPTH-1
SEL_W, clog2(DEPTH), forwarding select width
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
freeze  in  1  global pipeline hold (SRAM/cache not ready)
flush  in  1  branch taken in EXE; squash instruction leaving ID
forwarding_en  in  1  0 = stall on any RAW dependency, 1 = forward where possible
id_valid  in  1  ID holds a real instruction
id_src  in  NUM_SRC*AW  source register addresses, src i at bits [i*AW +: AW]
id_src_used  in  NUM_SRC  bit i set = src i is read (Two_src, store Rd, …)
id_dest  in  AW  destination register
id_wb_en  in  1  instruction writes id_dest
id_mem_r_en  in  1  instruction is a load
hazard  out  1  stall IF/ID this cycle
fwd_sel  out  NUM_SRC*SEL_W  per-source select for EXE operand: 0 = register file value, k = result of stage k
stall_count  out  CNT_W  saturating count of stall cycles

Behaviour:
- Record per stage k: valid, dest, wb_en, load. The EXE record additionally holds its src addresses and src_used bits.
- Reset (asynchronous, any time, including while frozen): all records invalid, all EXE src_used cleared, stall_count=0. Consequently hazard=0 and fwd_sel=0 while reset is asserted and on the first cycle after release.
- Match(i,k) = id_src_used[i] & rec[k].valid & rec[k].wb_en & rec[k].dest==id_src[i].
- hazard is combinational and asserts only when id_valid=1:
  - forwarding_en=0: hazard if Match(i,k) for any i and any k in 0..DEPTH-2. The WB stage never stalls, because the register file writes through.
  - forwarding_en=1: hazard if Match(i,k) with rec[k].load=1 and k < LOAD_READY-1. Default parameters give a one-cycle load-use stall against EXE only.
- fwd_sel[i] is combinational, from the EXE record's src i against stages k=1..DEPTH-1. The lowest matching k wins (youngest producer). A load at k < LOAD_READY is not a valid forward source. Output is 0 when forwarding_en=0, when src i is unused, or when there is no match. Matches against the register-address value with all bits set are still forwarded; there is no special register.
- Advance, on clock edge with freeze=0:
  - rec[k] <= rec[k-1] for k≥1.
  - rec[0] <= ID fields if id_valid & ~hazard & ~flush; otherwise a bubble (valid=0, src_used=0).
- freeze=1: all records, EXE srcs and stall_count hold. hazard and fwd_sel keep being evaluated combinationally from the held state. freeze dominates flush; a flush held during freeze takes effect on the first unfrozen edge.
- flush does not kill records already at k≥0; the branch itself proceeds.
- stall_count increments on edges where freeze=0, id_valid=1 and hazard=1. It saturates at all-ones.
- Simultaneous hazard and flush: the bubble is inserted and the stall is still counted.

Test Plan:
1. Reset mid-run with records full (rst pulsed asynchronously between edges) -> hazard=0, fwd_sel=0 and stall_count=0 immediately; the next instruction with src=R1 sees no stall.
2. forwarding_en=0: ADD R1 then SUB R2,R1,R3 back-to-back -> hazard=1 for 2 cycles, SUB enters EXE with fwd_sel=0, stall_count=2.
3. forwarding_en=1, same pair -> hazard never set; SUB in EXE with fwd_sel[0]=1. Insert one independent instruction between them -> fwd_sel[0]=2.
4. forwarding_en=1: LDR R4 then ADD R5,R4,R4 -> hazard=1 for exactly 1 cycle, then the ADD is in EXE with fwd_sel[0]=fwd_sel[1]=2. Repeat with DEPTH=4, LOAD_READY=3 -> 2 stall cycles, then select 3.
5. Two producers of R1 at MEM and WB -> fwd_sel=1 (youngest). Consumer with id_src_used[1]=0 and src2=R1 -> fwd_sel[1]=0.
6. freeze high for 5 cycles with a hazard present -> records and stall_count frozen; flush during freeze -> squash applied on the first unfrozen edge; stall_count with CNT_W=2 saturates at 3.
